// File: rtl/life_if.sv
// Control/board bundle between user logic, the Life controller and its datapath.
// The controller takes the slave side; the master side drives inputs and consumes outputs.
interface life_if #(
  parameter int unsigned GEN_W = 16
);
  logic [63:0]      seed;
  logic             load;
  logic             start;
  logic             stop;
  logic             step;
  logic [GEN_W-1:0] max_gen;
  logic [63:0]      grid;
  logic [63:0]      grid_evolve;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             done;
  logic             stable;
  logic             extinct;

  modport master (
    output seed, load, start, stop, step, max_gen, grid_evolve,
    input  grid, gen_count, busy, done, stable, extinct
  );

  modport slave (
    input  seed, load, start, stop, step, max_gen, grid_evolve,
    output grid, gen_count, busy, done, stable, extinct
  );
endinterface

// File: rtl/life_controller.sv
// Sequential owner of the 8x8 Game of Life board: loads seeds, paces generations
// through the external combinational datapath and halts on stop/limit/still-life/extinction.
module life_controller #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned GEN_W    = 16
) (
  input logic   clk,
  input logic   reset_n,
  life_if.slave bus
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      grid_q, grid_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;

  logic             tick_last;
  logic             fire;
  logic             evolve_zero;
  logic             evolve_same;
  logic             limit_hit;
  logic [GEN_W-1:0] gen_inc;

  // Halt conditions are judged on pre-advance grid/gen_count values.
  always_comb begin
    tick_last   = (tick_q == TICK_LAST);
    fire        = (state_q == S_RUN) && !bus.stop && tick_last;
    evolve_zero = (bus.grid_evolve == '0);
    evolve_same = (bus.grid_evolve == grid_q);
    limit_hit   = (bus.max_gen != '0) &&
                  (({1'b0, gen_q} + {{GEN_W{1'b0}}, 1'b1}) >= {1'b0, bus.max_gen});
    gen_inc     = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.load && bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.stop) state_d = S_HALT;
        else if (fire && (evolve_zero || evolve_same || limit_hit)) state_d = S_HALT;
      end
      S_HALT: begin
        if (bus.load)       state_d = S_IDLE;
        else if (bus.start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grid_d    = grid_q;
    gen_d     = gen_q;
    tick_d    = tick_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          grid_d    = bus.seed;
          gen_d     = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end else if (bus.start) begin
          tick_d = '0;
        end else if (bus.step) begin
          grid_d = bus.grid_evolve;
          gen_d  = gen_inc;
        end
      end
      S_RUN: begin
        if (!bus.stop) begin
          if (tick_last) begin
            tick_d = '0;
            grid_d = bus.grid_evolve;
            gen_d  = gen_inc;
            if (evolve_zero)      extinct_d = 1'b1;
            else if (evolve_same) stable_d  = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_HALT: begin
        if (bus.load) begin
          grid_d    = bus.seed;
          gen_d     = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end else if (bus.start) begin
          tick_d    = '0;
          stable_d  = 1'b0;
          extinct_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.grid      = grid_q;
    bus.gen_count = gen_q;
    bus.busy      = (state_q == S_RUN);
    bus.done      = (state_q == S_HALT);
    bus.stable    = stable_q;
    bus.extinct   = extinct_q;
  end

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with a non-wrapping 8x8 Life next-state feeding grid_evolve.
module tb_life_controller;

  localparam logic [63:0] BLINK_V = 64'h0000_0000_0002_0202;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_0000_0700;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  life_if #(.GEN_W(16)) bus ();

  life_controller #(.TICK_DIV(4), .GEN_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] nx;
    nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8)
              n += int'(g[(r + dr) * 8 + (c + dc)]);
          end
        end
        nx[r * 8 + c] = g[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return nx;
  endfunction

  assign bus.grid_evolve = life_next(bus.grid);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [63:0] s);
    bus.seed = s;
    bus.load = 1'b1;
    clks(1);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    clks(1);
    bus.start = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.seed    = '0;
    bus.load    = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.max_gen = '0;
    #12;
    chk("rst_grid", bus.grid, 64'h0);
    chk("rst_gen", 64'(bus.gen_count), 64'd0);
    chk("rst_flags", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    clks(1);

    // load+start together: load wins, stay IDLE
    bus.seed  = BLINK_V;
    bus.load  = 1'b1;
    bus.start = 1'b1;
    clks(1);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    chk("ls_grid", bus.grid, BLINK_V);
    chk("ls_busy", {63'd0, bus.busy}, 64'd0);
    clks(3);
    chk("ls_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.step = 1'b1;
    clks(1);
    bus.step = 1'b0;
    chk("step_grid", bus.grid, BLINK_H);
    chk("step_gen", 64'(bus.gen_count), 64'd1);
    chk("step_state", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'h0);

    // blinker with generation limit 3
    pulse_load(BLINK_V);
    chk("bl_gen0", 64'(bus.gen_count), 64'd0);
    bus.max_gen = 16'd3;
    pulse_start();
    chk("bl_busy", {63'd0, bus.busy}, 64'd1);
    clks(3);
    chk("bl_noadv", bus.grid, BLINK_V);
    clks(1);
    chk("bl_g1_grid", bus.grid, BLINK_H);
    chk("bl_g1_gen", 64'(bus.gen_count), 64'd1);
    clks(4);
    chk("bl_g2_grid", bus.grid, BLINK_V);
    chk("bl_g2_gen", 64'(bus.gen_count), 64'd2);
    clks(4);
    chk("bl_g3_gen", 64'(bus.gen_count), 64'd3);
    chk("bl_g3_flags", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b0100);
    chk("bl_g3_grid", bus.grid, BLINK_H);
    // resume past the limit: one more generation then halt again
    pulse_start();
    clks(4);
    chk("bl_g4_gen", 64'(bus.gen_count), 64'd4);
    chk("bl_g4_done", {62'd0, bus.busy, bus.done}, 64'b01);

    // still life
    pulse_load(BLOCK);
    chk("blk_idle", {62'd0, bus.busy, bus.done}, 64'b00);
    bus.max_gen = '0;
    pulse_start();
    clks(4);
    chk("blk_grid", bus.grid, BLOCK);
    chk("blk_gen", 64'(bus.gen_count), 64'd1);
    chk("blk_flags", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b0110);

    // extinction, then restart on an empty board
    pulse_load(64'h1);
    chk("ext_clr", {62'd0, bus.stable, bus.extinct}, 64'b00);
    pulse_start();
    clks(4);
    chk("ext_grid", bus.grid, 64'h0);
    chk("ext_gen", 64'(bus.gen_count), 64'd1);
    chk("ext_flags", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b0101);
    pulse_start();
    chk("ext2_clr", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b1000);
    clks(4);
    chk("ext2_flags", {60'd0, bus.busy, bus.done, bus.stable, bus.extinct}, 64'b0101);
    chk("ext2_gen", 64'(bus.gen_count), 64'd2);

    // stop coincides with the firing tick
    pulse_load(BLINK_V);
    pulse_start();
    clks(3);
    bus.stop = 1'b1;
    clks(1);
    bus.stop = 1'b0;
    chk("stop_grid", bus.grid, BLINK_V);
    chk("stop_gen", 64'(bus.gen_count), 64'd0);
    chk("stop_done", {62'd0, bus.busy, bus.done}, 64'b01);
    pulse_start();
    clks(3);
    chk("res_noadv", 64'(bus.gen_count), 64'd0);
    clks(1);
    chk("res_gen", 64'(bus.gen_count), 64'd1);
    chk("res_grid", bus.grid, BLINK_H);
    chk("res_busy", {63'd0, bus.busy}, 64'd1);

    // asynchronous reset in the middle of RUN
    clks(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_grid", bus.grid, 64'h0);
    chk("ar_gen", 64'(bus.gen_count), 64'd0);
    chk("ar_state", {62'd0, bus.busy, bus.done}, 64'b00);
    @(negedge clk);
    reset_n = 1'b1;
    clks(1);
    chk("ar_idle", {62'd0, bus.busy, bus.done}, 64'b00);
    bus.step = 1'b1;
    clks(1);
    bus.step = 1'b0;
    chk("ar_step_gen", 64'(bus.gen_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
